// File: rtl/barrido_pkg.sv
// Shared types and constants for the barrido sweep controller.
// State encoding plus MISR polynomial, seed and step function.
package barrido_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

    function automatic logic [15:0] misr_step(
        input logic [15:0] s,
        input logic [15:0] d
    );
        return {s[14:0], 1'b0} ^ (s[15] ? MISR_POLY : 16'h0000) ^ d;
    endfunction

endpackage

// File: rtl/barrido_if.sv
// Host and datapath-under-test signals of the sweep controller.
// master = host/datapath side, slave = controller side.
interface barrido_if #(
    parameter int N_IN  = 5,
    parameter int N_OUT = 3
);
    logic              start;
    logic              hold;
    logic [N_OUT-1:0]  resp_a;
    logic [N_OUT-1:0]  resp_b;
    logic [N_IN-1:0]   vec_out;
    logic              busy;
    logic              done;
    logic [N_IN:0]     mismatch_cnt;
    logic              first_fail_valid;
    logic [N_IN-1:0]   first_fail_vec;
    logic [15:0]       sig;

    modport master (
        output start, hold, resp_a, resp_b,
        input  vec_out, busy, done, mismatch_cnt,
        input  first_fail_valid, first_fail_vec, sig
    );

    modport slave (
        input  start, hold, resp_a, resp_b,
        output vec_out, busy, done, mismatch_cnt,
        output first_fail_valid, first_fail_vec, sig
    );
endinterface

// File: rtl/barrido_ctrl_misr16.sv
// 16-bit multiple-input signature register (poly 0x1021).
// clr reseeds, en folds din into the signature.
module misr16
    import barrido_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [15:0] din,
    output logic [15:0] sig
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sig <= MISR_SEED;
        else if (clr)
            sig <= MISR_SEED;
        else if (en)
            sig <= misr_step(sig, din);
    end

endmodule

// File: rtl/barrido_ctrl.sv
// Clocked, pausable sweep sequencer comparing two datapath responses.
// Define BARRIDO_MISR_EN to build the response signature (MISR) on sig.
module barrido_ctrl
    import barrido_pkg::*;
#(
    parameter int N_IN       = 5,
    parameter int N_OUT      = 3,
    parameter int SETTLE_CYC = 2
) (
    input  logic     clk,
    input  logic     rst,
    barrido_if.slave bus
);

    localparam int          CW       = N_IN + 1;
    localparam logic [3:0]  CNT_LAST = 4'(SETTLE_CYC - 1);

    state_t            state;
    logic [3:0]        cnt;
    logic [N_IN-1:0]   vec;
    logic              busy_q;
    logic              done_q;
    logic [CW-1:0]     mm_cnt;
    logic              ff_valid;
    logic [N_IN-1:0]   ff_vec;
    logic              launch;
    logic              cmp_cyc;

    assign launch  = (state == IDLE) && bus.start;
    assign cmp_cyc = (state == COMPARE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            vec      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mm_cnt   <= '0;
            ff_valid <= 1'b0;
            ff_vec   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        vec      <= '0;
                        cnt      <= '0;
                        mm_cnt   <= '0;
                        ff_valid <= 1'b0;
                        ff_vec   <= '0;
                        busy_q   <= 1'b1;
                        state    <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (!bus.hold) begin
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= COMPARE;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                COMPARE: begin
                    if (bus.resp_a != bus.resp_b) begin
                        mm_cnt <= mm_cnt + CW'(1);
                        if (!ff_valid) begin
                            ff_valid <= 1'b1;
                            ff_vec   <= vec;
                        end
                    end
                    // Stop at all-ones so vec_out never wraps mid-sweep
                    if (&vec) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        vec   <= vec + N_IN'(1);
                        state <= SETTLE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.vec_out          = vec;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.mismatch_cnt     = mm_cnt;
    assign bus.first_fail_valid = ff_valid;
    assign bus.first_fail_vec   = ff_vec;

`ifdef BARRIDO_MISR_EN
    misr16 u_misr (
        .clk (clk),
        .rst (rst),
        .clr (launch),
        .en  (cmp_cyc),
        .din (16'(bus.resp_a)),
        .sig (bus.sig)
    );
`else
    logic unused_ok;
    assign unused_ok = launch ^ cmp_cyc;
    assign bus.sig   = 16'h0000;
`endif

endmodule
